// File: rtl/d_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_pkg
// Purpose  : Shared state encoding and store-strobe helpers for d_cache_v3.
// Revision : 1.0
// ============================================================================
package d_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic strb_legal(input logic [3:0] wstrb);
        case (wstrb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Right-aligned store data is moved onto the strobed byte lanes.
    function automatic logic [31:0] lane_place(input logic [3:0] wstrb, input logic [31:0] wdata);
        case (wstrb)
            4'b0001: return {24'h0, wdata[7:0]};
            4'b0010: return {16'h0, wdata[7:0], 8'h0};
            4'b0100: return {8'h0, wdata[7:0], 16'h0};
            4'b1000: return {wdata[7:0], 24'h0};
            4'b0011: return {16'h0, wdata[15:0]};
            4'b1100: return {wdata[15:0], 16'h0};
            4'b1111: return wdata;
            default: return 32'h0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_cache_data_array.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_data_array
// Purpose  : Word-wide cache data store, per-byte write enable, 1-cycle read.
// Revision : 1.0
// ============================================================================
module d_cache_data_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                      clk,
    input  logic                                      rd_en,
    input  logic [$clog2(NUM_LINES*LINE_WORDS)-1:0]   rd_addr,
    output logic [31:0]                               rd_data,
    input  logic [3:0]                                wr_be,
    input  logic [$clog2(NUM_LINES*LINE_WORDS)-1:0]   wr_addr,
    input  logic [31:0]                               wr_data
);

    localparam int c_DEPTH = NUM_LINES * LINE_WORDS;

    logic [31:0] r_mem [c_DEPTH];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/d_cache_v3.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_v3
// Purpose  : Direct-mapped write-through, no-write-allocate data cache.
// Revision : 1.0
// ============================================================================
module d_cache_v3
    import d_cache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [3:0]  core_wstrb,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_err,
    input  logic        cache_flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int c_WORD_BITS  = $clog2(LINE_WORDS);
    localparam int c_INDEX_BITS = $clog2(NUM_LINES);
    localparam int c_OFF_BITS   = 2 + c_WORD_BITS;
    localparam int c_TAG_BITS   = 32 - c_OFF_BITS - c_INDEX_BITS;
    localparam int c_ARR_W      = c_WORD_BITS + c_INDEX_BITS;
    localparam int c_CNT_W      = c_WORD_BITS + 1;
    localparam logic [31:0] c_LINE_MASK = ~((32'd1 << c_OFF_BITS) - 32'd1);

    state_t                     r_state;
    state_t                     w_next;

    logic                       r_we;
    logic [3:0]                 r_wstrb;
    logic [31:0]                r_addr;
    logic [31:0]                r_wdata;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [31:0]                r_cap;
    logic [NUM_LINES-1:0]       r_valid;
    logic [c_TAG_BITS-1:0]      r_tags [NUM_LINES];
    logic                       r_flush_pend;
    logic [31:0]                r_hit_count;
    logic [31:0]                r_miss_count;

    logic [c_INDEX_BITS-1:0]    w_index;
    logic [c_TAG_BITS-1:0]      w_tag;
    logic                       w_hit;
    logic [31:0]                w_word_sel;
    logic                       w_cap_en;
    logic                       w_last;
    logic [31:0]                w_refill_addr;
    logic [31:0]                w_placed;

    logic                       w_accept;
    logic                       w_flush_now;
    logic                       w_refill_ack;
    logic                       w_hit_inc;
    logic                       w_miss_inc;
    logic [3:0]                 w_arr_be;
    logic [c_ARR_W-1:0]         w_arr_waddr;
    logic [31:0]                w_arr_wdata;
    logic [31:0]                w_arr_rdata;

    assign w_index       = r_addr[c_OFF_BITS +: c_INDEX_BITS];
    assign w_tag         = r_addr[31 -: c_TAG_BITS];
    assign w_hit         = r_valid[w_index] && (r_tags[w_index] == w_tag);
    assign w_word_sel    = (r_addr >> 2) & 32'(LINE_WORDS - 1);
    assign w_cap_en      = (32'(r_cnt) == w_word_sel);
    assign w_last        = (r_cnt == c_CNT_W'(LINE_WORDS - 1));
    assign w_refill_addr = (r_addr & c_LINE_MASK) + (32'(r_cnt) << 2);
    assign w_placed      = lane_place(r_wstrb, r_wdata);

    d_cache_data_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data_array (
        .clk     (clk),
        .rd_en   (w_accept),
        .rd_addr (core_addr[2 +: c_ARR_W]),
        .rd_data (w_arr_rdata),
        .wr_be   (w_arr_be),
        .wr_addr (w_arr_waddr),
        .wr_data (w_arr_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        core_ready   = 1'b0;
        core_err     = 1'b0;
        core_rdata   = 32'h0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wstrb    = 4'h0;
        mem_wdata    = 32'h0;
        w_accept     = 1'b0;
        w_flush_now  = 1'b0;
        w_refill_ack = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_arr_be     = 4'h0;
        w_arr_waddr  = r_addr[2 +: c_ARR_W];
        w_arr_wdata  = 32'h0;
        case (r_state)
            ST_IDLE: begin
                // A pending or live flush wins over a waiting request.
                if (r_flush_pend || cache_flush) begin
                    w_flush_now = 1'b1;
                end else if (core_req) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (r_we && !strb_legal(r_wstrb)) begin
                    core_ready = 1'b1;
                    core_err   = 1'b1;
                    w_next     = ST_IDLE;
                end else if (!r_we) begin
                    if (w_hit) begin
                        core_ready = 1'b1;
                        core_rdata = w_arr_rdata;
                        w_hit_inc  = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_miss_inc = 1'b1;
                        w_next     = ST_REFILL;
                    end
                end else begin
                    w_next = ST_WRITE;
                    if (w_hit) begin
                        w_arr_be    = r_wstrb;
                        w_arr_wdata = w_placed;
                        w_hit_inc   = 1'b1;
                    end else begin
                        w_miss_inc = 1'b1;
                    end
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = w_refill_addr;
                if (mem_ack) begin
                    w_refill_ack = 1'b1;
                    w_arr_be     = 4'hF;
                    w_arr_waddr  = w_refill_addr[2 +: c_ARR_W];
                    w_arr_wdata  = mem_rdata;
                    if (w_last) begin
                        w_next = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wstrb = r_wstrb;
                mem_wdata = w_placed;
                if (mem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                core_ready = 1'b1;
                core_rdata = r_we ? 32'h0 : r_cap;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_wstrb      <= 4'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_cnt        <= '0;
            r_cap        <= 32'h0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we    <= core_we;
                r_wstrb <= core_wstrb;
                r_addr  <= core_addr;
                r_wdata <= core_wdata;
                r_cnt   <= '0;
            end
            // The line only becomes valid once every word has landed.
            if (w_refill_ack) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_cap_en) begin
                    r_cap <= mem_rdata;
                end
                if (w_last) begin
                    r_valid[w_index] <= 1'b1;
                end
            end
            if (w_flush_now) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end else if (cache_flush && (r_state != ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit_inc && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_inc && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_refill_ack && w_last) begin
            r_tags[w_index] <= w_tag;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: doc/d_cache_v3.md
# d_cache_v3

Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's load/store port and a word-wide backing memory port with a req/ack handshake. It adds tags, valid bits, line refill, a flush, illegal-strobe error reporting and hit/miss counters. It keeps the core-side strobe and lane-placement semantics of the existing data memory.

## Interface
- `NUM_LINES`, default 64: number of lines; power of two, ≥2.
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, ≥1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_req` in 1: access request; held with stable fields until `core_ready`.
- `core_we` in 1: 1 = store, 0 = load.
- `core_wstrb` in 4: byte-lane strobe, stores only.
- `core_addr` in 32: byte address.
- `core_wdata` in 32: right-aligned store data.
- `core_rdata` out 32: full aligned word; valid while `core_ready` is high.
- `core_ready` out 1: one-cycle completion pulse.
- `core_err` out 1: pulses with `core_ready` when a store uses an illegal strobe.
- `cache_flush` in 1: invalidate all lines.
- `mem_req` out 1: backing request.
- `mem_we` out 1: backing write.
- `mem_addr` out 32: word-aligned backing address; bits [1:0] are always 0.
- `mem_wstrb` out 4: backing strobe.
- `mem_wdata` out 32: lane-placed store data.
- `mem_ack` in 1: one-cycle acknowledge; ignored while `mem_req` is low.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `hit_count` out 32: number of hits; saturates at 0xFFFFFFFF.
- `miss_count` out 32: number of misses; saturates at 0xFFFFFFFF.

## Operation
- Address split: [1:0] byte; [2 +: log2(LINE_WORDS)] word; next log2(NUM_LINES) bits index; remaining bits tag.
- Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Lane placement:
  - Single-byte strobe: lane ← wdata[7:0].
  - 0011 / 1100: lanes ← wdata[15:0].
  - 1111: word ← wdata.
  - Unstrobed lanes are 0.
- FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE:
  - If a flush is pending or `cache_flush` is high: clear all valid bits and the pending flag, stay in IDLE. Flush has priority over `core_req`.
  - Else if `core_req` is high: register the request, start the tag/data array read, go to LOOKUP.
- LOOKUP:
  - Illegal store strobe: `core_ready` = `core_err` = 1; no array or memory write; go to IDLE.
  - Load hit: `core_ready` = 1, `core_rdata` = array word; `hit_count`++; go to IDLE.
  - Load miss: `miss_count`++; go to REFILL.
  - Store: go to WRITE. If it hits, write the strobed lanes into the array this cycle and `hit_count`++; otherwise `miss_count`++ and the array is unchanged.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = line base + 4·cnt, cnt starts at 0.
  - On each `mem_ack`: write `mem_rdata` into the array, capture the word if cnt equals the requested word, then cnt++.
  - After the last ack: set tag and valid, go to RESP.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr` = word address, `mem_wstrb` = `core_wstrb`, `mem_wdata` = lane-placed data.
  - On `mem_ack`, go to RESP.
- RESP: `core_ready`=1. For a load, `core_rdata` = captured word; for a store, `core_rdata` = 0. Go to IDLE.
- A `cache_flush` seen outside IDLE sets the pending flag; it takes effect on the next IDLE cycle.
- Reset: FSM → IDLE, all valid bits and counters 0, flush flag 0, and every output 0. A reset that arrives mid-refill leaves the line invalid.

## Timing
- Load hit: request sampled at edge N; `core_ready` high during cycle N+1.
- Miss: `core_ready` high in the cycle after the final `mem_ack`.
- Store: `core_ready` high in the cycle after `mem_ack`.
- `mem_req` and its address/data are registered and stable until acknowledged. After a non-final refill ack, the next address is presented in the following cycle with `mem_req` still high.
- `core_ready` is never high in two consecutive cycles. A new request is accepted no earlier than the cycle after `core_ready`.
- Data array: synchronous read, 1-cycle latency, per-byte write enable.

## Structure
- `d_cache_pkg` contains:
  - the state enum;
  - function `strb_legal(wstrb)`;
  - function `lane_place(wstrb, wdata)`.
- Sub-module `d_cache_data_array`: parametrised `NUM_LINES`·`LINE_WORDS` × 32 array, byte write enables, synchronous read.
- Tags and valid bits are held in flops in the top level.

## Test plan
All scenarios use the default parameters.
1. Reset, then load 0x108; memory answers 0x100..0x10C with 0x11, 0x22, 0x33, 0x44 → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; `core_rdata` = 0x33; `miss_count` = 1.
2. Load 0x108 again → `core_ready` at N+1, `core_rdata` = 0x33, no `mem_req`, `hit_count` = 1.
3. Store to 0x104 with strobe 0100, data 0xAB → `mem_wdata` = 0x00AB0000, `mem_wstrb` = 0100. A following load of 0x104 returns 0x00AB0022.
4. Store with strobe 0101 → `core_ready` and `core_err` pulse; no `mem_req`; load 0x104 still returns 0x00AB0022.
5. Load 0x500, which has the same index as 0x100 → refill. Then load 0x100 → miss and refill. Then `cache_flush` followed by a load of 0x500 → miss.
6. Assert `rst_n` low after the 2nd refill ack → `mem_req` drops immediately, both counters read 0. Load 0x100 afterwards → full 4-word refill.
